bist_misr_analyzer: RTL
=======================

Name: bist_misr_analyzer

Overview:
- Response-side stage of the ATPG/BIST path, directly downstream of the 5-bit pattern LFSR.
- The LFSR pattern drives the circuit under test (CUT), and the CUT response feeds this block.
- The block sequences a fixed-length test session and compresses each response into a multiple-input signature register (MISR).
- At session end it compares the signature against a golden value and reports pass/fail.

Parameters:
- WIDTH, 5, response and signature width in bits (>=2).
- POLY, 5'b10100, MISR feedback tap mask; bit i set means sig[i] enters the feedback XOR (default taps x^5+x^3+1).
- SEED, 5'b00000, signature value loaded at session start.
- GOLDEN, 5'h00, expected final signature.
- NUM_PATTERNS, 31, responses compressed per session (1..255).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a session; honoured only in IDLE or DONE.
- abort  in  1  synchronous abort; returns to IDLE.
- resp_valid  in  1  cut_resp is valid this cycle.
- cut_resp  in  WIDTH  CUT response for the current pattern.
- pat_en  out  1  high in RUN; upstream LFSR/CUT may advance.
- lfsr_clr  out  1  one-cycle pulse when a start is accepted; reseeds upstream LFSR.
- busy  out  1  high in RUN or COMPARE.
- done  out  1  high in DONE.
- pass  out  1  valid while done is high; 1 = signature equals GOLDEN.
- signature  out  WIDTH  current MISR contents.
- pat_count  out  8  responses compressed in the current session.

Behaviour:
- Reset: asynchronous, on rst_n low.
  - state=IDLE, signature=SEED, pat_count=0.
  - pat_en=0, lfsr_clr=0, busy=0, done=0, pass=0.
- States: IDLE, RUN, COMPARE, DONE. All outputs are registered or decoded from registered state.
- IDLE or DONE with start=1 and abort=0:
  - Next state RUN; signature<=SEED; pat_count<=0; pass<=0; lfsr_clr pulses high for exactly that next cycle.
- RUN, each edge with resp_valid=1: compress the response.
  - fb = XOR-reduce(signature & POLY).
  - sig'[0] = fb ^ cut_resp[0].
  - sig'[i] = signature[i-1] ^ cut_resp[i], for i=1..WIDTH-1.
  - pat_count increments by 1.
- RUN with resp_valid=0: signature and pat_count hold.
- RUN exit: when the edge compressing a response sees pat_count==NUM_PATTERNS-1, next state is COMPARE. pat_count ends at NUM_PATTERNS; no wrap.
- COMPARE: one cycle. pat_en=0, and cut_resp is ignored even if resp_valid is high.
  - pass<=(signature==GOLDEN); next state DONE.
- Latency: done and pass become visible the cycle after COMPARE, i.e. two edges after the edge compressing the final response.
- DONE: done=1; signature, pass and pat_count hold until start or abort.
- start while busy: ignored, no effect.
- abort (any state, highest priority over start and resp_valid):
  - Next state IDLE; pass<=0; done falls.
  - signature and pat_count hold their last values for debug.
- start and abort in the same cycle: abort wins; state IDLE; no lfsr_clr.
- resp_valid outside RUN: ignored.
- rst_n low mid-session: immediate return to reset values. No partial result is reported.

Test Plan:
1. Reset with rst_n=0 mid-RUN -> all outputs return to reset values asynchronously, before the next clk edge; state IDLE.
2. NUM_PATTERNS=3, SEED=0, GOLDEN=5'h04; start, then responses 5'h01, 5'h00, 5'h00 -> signature 5'h01, 5'h02, 5'h04; lfsr_clr one pulse; done=1 and pass=1 two edges after the third response; pat_count=3.
3. NUM_PATTERNS=3, responses 5'h1F x3 -> signature 5'h1F, 5'h01, 5'h1D. With GOLDEN=5'h04, pass=0 and done=1.
4. resp_valid gaps: responses in scenario 2 interleaved with idle cycles (resp_valid=0) -> identical final signature 5'h04; pat_en stays high throughout RUN.
5. abort after 2 responses -> IDLE next cycle; busy=0, done=0; signature holds 5'h02. A subsequent start reloads SEED and pulses lfsr_clr.
6. start asserted during RUN, and simultaneous start+abort in DONE -> first has no effect; second ends in IDLE with no lfsr_clr pulse.

Source files
------------

// File: rtl/bist_misr_analyzer.sv
// -----------------------------------------------------------------------------
// bist_misr_analyzer
//   Response-side stage of the BIST path. Runs a fixed-length test session and
//   compresses each CUT response into a multiple-input signature register
//   (MISR). At session end it compares the signature against GOLDEN and
//   reports pass/fail.
//
// Ports
//   clk        : system clock, rising-edge active
//   rst_n      : asynchronous active-low reset
//   start      : request to begin a session (honoured in IDLE or DONE only)
//   abort      : synchronous abort back to IDLE (highest priority)
//   resp_valid : cut_resp is valid this cycle
//   cut_resp   : CUT response for the current pattern
//   pat_en     : high in RUN, upstream LFSR/CUT may advance
//   lfsr_clr   : one-cycle pulse after a start is accepted, reseeds the LFSR
//   busy       : high in RUN or COMPARE
//   done       : high in DONE
//   pass       : valid while done is high, 1 = signature matched GOLDEN
//   signature  : current MISR contents
//   pat_count  : responses compressed in the current session
// -----------------------------------------------------------------------------
module bist_misr_analyzer #(
  parameter int               WIDTH        = 5,
  parameter logic [WIDTH-1:0] POLY         = 5'b10100,
  parameter logic [WIDTH-1:0] SEED         = 5'b00000,
  parameter logic [WIDTH-1:0] GOLDEN       = 5'h00,
  parameter int               NUM_PATTERNS = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] cut_resp,
  output logic             pat_en,
  output logic             lfsr_clr,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [7:0]       pat_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [7:0] LAST_COUNT = 8'(NUM_PATTERNS - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] sig_next;
  logic [WIDTH-1:0] misr_step;
  logic [7:0]       count_next;
  logic             pass_next;
  logic             clr_next;
  logic             fb;

  // One MISR shift: the tapped feedback enters bit 0, every other bit takes
  // its lower neighbour, and the response is XORed in across all bits.
  always_comb begin
    misr_step = '0;
    fb        = ^(signature & POLY);
    misr_step[0] = fb ^ cut_resp[0];
    for (int i = 1; i < WIDTH; i++) begin
      misr_step[i] = signature[i-1] ^ cut_resp[i];
    end
  end

  // Next-state and next-register logic. Abort is checked first so that it
  // overrides both start and resp_valid; signature and pat_count are left
  // untouched on abort so the partial session stays visible for debug.
  always_comb begin
    state_next = state;
    sig_next   = signature;
    count_next = pat_count;
    pass_next  = pass;
    clr_next   = 1'b0;

    if (abort) begin
      state_next = IDLE;
      pass_next  = 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state_next = RUN;
            sig_next   = SEED;
            count_next = '0;
            pass_next  = 1'b0;
            clr_next   = 1'b1;
          end
        end
        RUN: begin
          if (resp_valid) begin
            sig_next   = misr_step;
            count_next = pat_count + 8'd1;
            if (pat_count == LAST_COUNT) begin
              state_next = COMPARE;
            end
          end
        end
        COMPARE: begin
          pass_next  = (signature == GOLDEN);
          state_next = DONE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      signature <= SEED;
      pat_count <= '0;
      pass      <= 1'b0;
      lfsr_clr  <= 1'b0;
    end else begin
      state     <= state_next;
      signature <= sig_next;
      pat_count <= count_next;
      pass      <= pass_next;
      lfsr_clr  <= clr_next;
    end
  end

  // Status outputs decoded straight from the registered state.
  assign pat_en = (state == RUN);
  assign busy   = (state == RUN) || (state == COMPARE);
  assign done   = (state == DONE);

endmodule
